// File: rtl/inference_sequencer.sv
// -----------------------------------------------------------------------------
// inference_sequencer
//
// Top-level controller for the MNIST inference pipeline. A single accepted
// start runs NUM_LAYERS layer engines one after another through start/done
// pulse pairs. Each layer is guarded by an optional watchdog. After the last
// layer the block streams the logits buffer and reports three results:
// - the argmax index;
// - the top-1 value;
// - the top-1 minus top-2 margin.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             request a run (accepted only while busy=0)
//   timeout_cycles    per-layer watchdog limit, sampled on accepted start
//                     (0 disables the watchdog)
//   busy              run in progress
//   done              one-cycle completion pulse (success or timeout)
//   error, err_layer  last run timed out, and the index of the stuck layer
//   layer_start       one-hot, one-cycle start pulse to layer k
//   layer_done        done pulse from layer k
//   logit_rd/addr     logits memory read strobe and address
//   logit_data        signed read data, valid one cycle after logit_rd
//   predicted_class   argmax index
//   max_logit         signed top-1 value
//   margin            unsigned top-1 minus top-2, one bit wider than a logit
// -----------------------------------------------------------------------------
module inference_sequencer #(
    parameter int NUM_LAYERS  = 2,
    parameter int NUM_CLASSES = 10,
    parameter int LOGIT_W     = 32,
    parameter int TO_W        = 24,
    localparam int LI_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int CI_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TO_W-1:0]       timeout_cycles,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LI_W-1:0]       err_layer,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic                  logit_rd,
    output logic [CI_W-1:0]       logit_addr,
    input  logic [LOGIT_W-1:0]    logit_data,
    output logic [CI_W-1:0]       predicted_class,
    output logic [LOGIT_W-1:0]    max_logit,
    output logic [LOGIT_W:0]      margin
);

    localparam int SC_W = $clog2(NUM_CLASSES + 1);
    localparam logic signed [LOGIT_W-1:0] MOST_NEG = {1'b1, {(LOGIT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_LSTART, S_LWAIT, S_SCAN, S_FIN, S_FAIL
    } state_t;

    state_t            state, state_nxt;
    logic [LI_W-1:0]   li;
    logic [TO_W-1:0]   to_r;
    logic [TO_W-1:0]   wd_cnt;
    logic [SC_W-1:0]   scan_cnt;
    logic              start_acc;
    logic              li_done;
    logic              li_last;
    logic              wd_expire;
    logic              scan_end;

    // Top-1 minus top-2, sign-extended by one bit so the full signed span
    // (max positive minus most negative) cannot wrap.
    function automatic logic [LOGIT_W:0] calc_margin(
        input logic signed [LOGIT_W-1:0] hi,
        input logic signed [LOGIT_W-1:0] lo
    );
        return {hi[LOGIT_W-1], hi} - {lo[LOGIT_W-1], lo};
    endfunction

    // The done cycle (FIN/FAIL) already reports busy=0, so a start seen there
    // is accepted, which is what gives back-to-back runs with no idle gap.
    assign start_acc = start && ((state == S_IDLE) || (state == S_FIN) || (state == S_FAIL));
    assign li_done   = layer_done[li];
    assign li_last   = (li == LI_W'(NUM_LAYERS - 1));
    // wd_cnt is 0 in the first wait cycle, so reaching limit-1 means the
    // layer has had exactly timeout_cycles wait cycles to answer.
    assign wd_expire = (to_r != '0) && (wd_cnt == (to_r - TO_W'(1)));
    // SCAN runs one extra cycle after the last read to absorb its data.
    assign scan_end  = (scan_cnt == SC_W'(NUM_CLASSES));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_LSTART;
            S_LSTART: state_nxt = S_LWAIT;
            S_LWAIT: begin
                if (li_done)        state_nxt = li_last ? S_SCAN : S_LSTART;
                else if (wd_expire) state_nxt = S_FAIL;
            end
            S_SCAN:   if (scan_end) state_nxt = S_FIN;
            S_FIN,
            S_FAIL:   state_nxt = start ? S_LSTART : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        layer_start = '0;
        logit_rd    = 1'b0;
        logit_addr  = '0;
        unique case (state)
            S_LSTART: begin
                busy            = 1'b1;
                layer_start[li] = 1'b1;
            end
            S_LWAIT:  busy = 1'b1;
            S_SCAN: begin
                busy = 1'b1;
                if (!scan_end) begin
                    logit_rd   = 1'b1;
                    logit_addr = CI_W'(scan_cnt);
                end
            end
            S_FIN,
            S_FAIL:   done = 1'b1;
            default:  ;
        endcase
    end

    // Control counters and error status
    always_ff @(posedge clk) begin
        if (rst) begin
            li        <= '0;
            to_r      <= '0;
            wd_cnt    <= '0;
            scan_cnt  <= '0;
            error     <= 1'b0;
            err_layer <= '0;
        end else begin
            if (start_acc) begin
                li        <= '0;
                to_r      <= timeout_cycles;
                error     <= 1'b0;
                err_layer <= '0;
            end else if ((state == S_LWAIT) && li_done && !li_last) begin
                li <= li + LI_W'(1);
            end
            wd_cnt   <= (state == S_LWAIT) ? wd_cnt + TO_W'(1) : '0;
            scan_cnt <= (state == S_SCAN) ? scan_cnt + SC_W'(1) : '0;
            if ((state == S_LWAIT) && !li_done && wd_expire) begin
                error     <= 1'b1;
                err_layer <= li;
            end
        end
    end

    // Stage p1: read data returns one cycle after the strobe
    logic            vld_p1;
    logic [CI_W-1:0] idx_p1;

    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= logit_rd;
    end

    always_ff @(posedge clk) begin
        idx_p1 <= logit_addr;
    end

    logic signed [LOGIT_W-1:0] data_p1;
    logic signed [LOGIT_W-1:0] best_nxt, second_nxt;
    logic [CI_W-1:0]           best_idx_nxt;

    // Stage p2: running best / second-best
    logic signed [LOGIT_W-1:0] best_p2, second_p2;
    logic [CI_W-1:0]           best_idx_p2;

    assign data_p1 = logit_data;

    // Strict '>' on best keeps the lowest index on ties; a value equal to
    // best then lands in second, giving a zero margin.
    always_comb begin
        best_nxt     = best_p2;
        second_nxt   = second_p2;
        best_idx_nxt = best_idx_p2;
        if (idx_p1 == '0) begin
            best_nxt     = data_p1;
            second_nxt   = MOST_NEG;
            best_idx_nxt = '0;
        end else if (data_p1 > best_p2) begin
            second_nxt   = best_p2;
            best_nxt     = data_p1;
            best_idx_nxt = idx_p1;
        end else if (data_p1 > second_p2) begin
            second_nxt   = data_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            best_p2     <= best_nxt;
            second_p2   <= second_nxt;
            best_idx_p2 <= best_idx_nxt;
        end
    end

    // Result registers: loaded from the last element's update so they are
    // visible together with done in the FIN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            predicted_class <= '0;
            max_logit       <= '0;
            margin          <= '0;
        end else if ((state == S_SCAN) && scan_end) begin
            predicted_class <= best_idx_nxt;
            max_logit       <= best_nxt;
            margin          <= calc_margin(best_nxt, second_nxt);
        end
    end

endmodule

// File: tb/tb_inference_sequencer.sv
`timescale 1ns/1ps
module tb_inference_sequencer;
    localparam int NL  = 2;
    localparam int NC  = 10;
    localparam int LW  = 32;
    localparam int TW  = 24;
    localparam int LIW = 1;
    localparam int CIW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [TW-1:0] timeout_cycles = '0;
    logic          busy, done, error;
    logic [LIW-1:0] err_layer;
    logic [NL-1:0] layer_start;
    logic [NL-1:0] layer_done = '0;
    logic          logit_rd;
    logic [CIW-1:0] logit_addr;
    logic [LW-1:0] logit_data = '0;
    logic [CIW-1:0] predicted_class;
    logic [LW-1:0] max_logit;
    logic [LW:0]   margin;

    inference_sequencer #(
        .NUM_LAYERS(NL), .NUM_CLASSES(NC), .LOGIT_W(LW), .TO_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .timeout_cycles(timeout_cycles),
        .busy(busy), .done(done), .error(error), .err_layer(err_layer),
        .layer_start(layer_start), .layer_done(layer_done),
        .logit_rd(logit_rd), .logit_addr(logit_addr), .logit_data(logit_data),
        .predicted_class(predicted_class), .max_logit(max_logit), .margin(margin)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int cyc    = 0;

    logic signed [LW-1:0] mem [NC];
    int dly [NL];
    int done_at [NL];
    bit echo_early = 1'b0;
    logic rd_q = 1'b0;
    logic [CIW-1:0] addr_q = '0;
    int ls_cnt, rd_cnt, rd_first, rd_last, rd_bad, ls_bad, done_busy_bad;
    int ls_cyc [NL];
    int ls0_q[$];
    int done_q[$];
    logic [NL-1:0] ls_prev = '0;

    logic [CIW-1:0] last_pred = '0;
    logic [LW-1:0]  last_max  = '0;
    logic [LW:0]    last_mg   = '0;

    int t1v [NC] = '{-5, 3, 7, 2, 7, -1, 0, 6, 1, -9};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample just after the edge, then drive the inputs for this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        logit_data = rd_q ? mem[addr_q] : '0;
        rd_q   = logit_rd;
        addr_q = logit_addr;
        layer_done = '0;
        for (int k = 0; k < NL; k++)
            if (done_at[k] == cyc) begin
                layer_done[k] = 1'b1;
                done_at[k] = -1;
            end
        if ($countones(layer_start) > 1) ls_bad++;
        if ((layer_start & ls_prev) != '0) ls_bad++;
        ls_prev = layer_start;
        for (int k = 0; k < NL; k++)
            if (layer_start[k]) begin
                ls_cnt++;
                ls_cyc[k] = cyc;
                if (k == 0) ls0_q.push_back(cyc);
                if (dly[k] > 0) done_at[k] = cyc + dly[k];
                if (echo_early) layer_done[k] = 1'b1;
            end
        if (logit_rd) begin
            if (rd_cnt == 0) rd_first = cyc;
            if (int'(logit_addr) != (rd_cnt % NC)) rd_bad++;
            rd_cnt++;
            rd_last = cyc;
        end
        if (done) begin
            done_q.push_back(cyc);
            if (busy) done_busy_bad++;
        end
    endtask

    task automatic clear_stats();
        ls_cnt = 0; rd_cnt = 0; rd_first = -1; rd_last = -1;
        rd_bad = 0; ls_bad = 0; done_busy_bad = 0;
        ls0_q.delete();
        done_q.delete();
        for (int k = 0; k < NL; k++) ls_cyc[k] = -1;
    endtask

    // Reference: argmax = first index holding the maximum; second = maximum of
    // the remaining entries (so a duplicated maximum yields a zero margin).
    function automatic void ref_model(output logic [CIW-1:0] idx, output logic [LW-1:0] mx,
                                      output logic [LW:0] mg);
        longint best, second;
        int bi;
        bit have2;
        best = longint'(mem[0]);
        bi = 0;
        for (int i = 1; i < NC; i++)
            if (longint'(mem[i]) > best) begin
                best = longint'(mem[i]);
                bi = i;
            end
        second = 0;
        have2 = 1'b0;
        for (int i = 0; i < NC; i++)
            if (i != bi && (!have2 || longint'(mem[i]) > second)) begin
                second = longint'(mem[i]);
                have2 = 1'b1;
            end
        idx = CIW'(bi);
        mx  = LW'(best);
        mg  = (LW+1)'(best - second);
    endfunction

    // Expected done cycle from the timing rules, given the layer_start[0] cycle.
    function automatic int exp_done_cyc(input int s0, input int to, output bit fail, output int fl);
        int s;
        s = s0;
        fail = 1'b0;
        fl = 0;
        for (int k = 0; k < NL; k++) begin
            if (dly[k] <= 0 || (to != 0 && dly[k] > to)) begin
                fail = 1'b1;
                fl = k;
                return s + to + 1;
            end
            if (k == NL - 1) return s + dly[k] + NC + 2;
            s = s + dly[k] + 1;
        end
        return -1;
    endfunction

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_q.size() > 0) break;
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_err_layer"}, err_layer, 0);
        check({tag, "_layer_start"}, layer_start, 0);
        check({tag, "_logit_rd"}, logit_rd, 0);
        check({tag, "_logit_addr"}, logit_addr, 0);
        check({tag, "_pred"}, predicted_class, 0);
        check({tag, "_max"}, max_logit, 0);
        check({tag, "_margin"}, margin, 0);
    endtask

    task automatic check_result(input string tag, input int c0, input int to);
        int expd, fl, dc;
        bit fail;
        logic [CIW-1:0] ei;
        logic [LW-1:0] em;
        logic [LW:0] eg;
        expd = exp_done_cyc(c0 + 1, to, fail, fl);
        wait_done(expd - c0 + 20);
        dc = (done_q.size() > 0) ? done_q[0] : -1;
        check({tag, "_done_cycle"}, dc, expd);
        check({tag, "_error"}, error, fail);
        check({tag, "_done_busy"}, done_busy_bad, 0);
        check({tag, "_ls_onehot"}, ls_bad, 0);
        if (fail) begin
            check({tag, "_err_layer"}, err_layer, fl);
            check({tag, "_ls_cnt"}, ls_cnt, fl + 1);
            check({tag, "_no_reads"}, rd_cnt, 0);
            check({tag, "_pred_held"}, predicted_class, last_pred);
            check({tag, "_max_held"}, max_logit, last_max);
            check({tag, "_margin_held"}, margin, last_mg);
        end else begin
            ref_model(ei, em, eg);
            check({tag, "_ls_cnt"}, ls_cnt, NL);
            check({tag, "_rd_first"}, rd_first, expd - NC - 1);
            check({tag, "_rd_last"}, rd_last, expd - 2);
            check({tag, "_rd_cnt"}, rd_cnt, NC);
            check({tag, "_rd_addr"}, rd_bad, 0);
            check({tag, "_pred"}, predicted_class, ei);
            check({tag, "_max"}, max_logit, em);
            check({tag, "_margin"}, margin, eg);
            last_pred = ei;
            last_max  = em;
            last_mg   = eg;
        end
        tick();
        check({tag, "_done_single"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic run_check(input string tag, input logic [TW-1:0] to);
        int c0;
        clear_stats();
        timeout_cycles = to;
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        timeout_cycles = TW'($urandom);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ls0"}, layer_start, 1);
        check({tag, "_err_clr"}, error, 0);
        check({tag, "_err_layer_clr"}, err_layer, 0);
        check_result(tag, c0, int'(to));
    endtask

    task automatic fill_random(input bit narrow);
        for (int i = 0; i < NC; i++)
            mem[i] = narrow ? LW'(int'($urandom_range(0, 8)) - 4) : LW'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int c0, expd, fl, v;
        bit fail;
        for (int k = 0; k < NL; k++) begin
            done_at[k] = -1;
            dly[k] = 1;
        end
        for (int i = 0; i < NC; i++) mem[i] = '0;
        clear_stats();

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Directed example from the spec
        for (int i = 0; i < NC; i++) mem[i] = LW'(t1v[i]);
        dly[0] = 20; dly[1] = 15;
        run_check("t1", '0);
        check("t1_pred_const", predicted_class, 2);
        check("t1_max_const", max_logit, 7);
        check("t1_margin_const", margin, 0);

        // Single large winner at the last index
        for (int i = 0; i < NC; i++) mem[i] = -100;
        mem[9] = 50;
        dly[0] = 4; dly[1] = 7;
        run_check("t2", '0);
        check("t2_pred_const", predicted_class, 9);
        check("t2_margin_const", margin, 150);

        // Extreme span: margin needs the extra bit
        mem[0] = 32'h7FFF_FFFF;
        for (int i = 1; i < NC; i++) mem[i] = 32'h8000_0000;
        run_check("t3", '0);
        check("t3_margin_const", margin, 33'h0_FFFF_FFFF);
        check("t3_pred_const", predicted_class, 0);

        // Done exactly at the watchdog limit is still accepted
        fill_random(1'b0);
        dly[0] = 8; dly[1] = 3;
        run_check("wd_edge", 24'd8);

        // Layer 1 never completes
        dly[0] = 5; dly[1] = -1;
        run_check("to_l1", 24'd8);
        check("to_l1_err_layer_const", err_layer, 1);
        check("to_l1_err_held", error, 1);

        // Next start clears error and completes
        fill_random(1'b1);
        dly[0] = 3; dly[1] = 2;
        run_check("after_to", '0);

        // Layer 0 timeout with the smallest limit
        dly[0] = -1;
        run_check("to_l0", 24'd1);
        check("to_l0_err_layer_const", err_layer, 0);
        dly[0] = 2;

        // Wrong-layer done, done echoed in the start cycle, start while busy
        fill_random(1'b1);
        clear_stats();
        dly[0] = 12; dly[1] = 6;
        echo_early = 1'b1;
        timeout_cycles = '0;
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        tick();
        tick();
        layer_done[1] = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_result("ignore", c0, 0);
        echo_early = 1'b0;
        check("ignore_ls1_cycle", ls_cyc[1], c0 + 1 + 12 + 1);
        repeat (40) tick();
        check("ignore_one_done", done_q.size(), 1);
        check("ignore_ls_total", ls_cnt, NL);

        // Randomised runs, some with timeouts
        for (int r = 0; r < 8; r++) begin
            fill_random(r[0]);
            for (int k = 0; k < NL; k++) dly[k] = $urandom_range(1, 10);
            run_check($sformatf("rand%0d", r), ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(3, 12)));
        end

        // Reset in the middle of SCAN
        fill_random(1'b0);
        dly[0] = 2; dly[1] = 3;
        clear_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (logit_rd && logit_addr == 4'd4) break;
            tick();
        end
        check("rst_scan_reached", logit_rd, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rst_scan");
        for (int k = 0; k < NL; k++) done_at[k] = -1;
        last_pred = '0; last_max = '0; last_mg = '0;
        repeat (30) tick();
        check("rst_scan_no_done", done_q.size(), 0);
        fill_random(1'b1);
        run_check("after_rst", '0);

        // start held high: back-to-back runs
        fill_random(1'b0);
        dly[0] = 3; dly[1] = 4;
        clear_stats();
        timeout_cycles = '0;
        start = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 300; i++) begin
            if (done_q.size() >= 3) break;
            tick();
        end
        start = 1'b0;
        check("b2b_done_cnt", done_q.size(), 3);
        check("b2b_ls0_cnt", ls0_q.size(), 3);
        v = (ls0_q.size() > 0) ? ls0_q[0] : -1;
        check("b2b_first_ls0", v, c0 + 1);
        for (int i = 0; i < 3; i++) begin
            int s, d;
            s = (ls0_q.size() > i) ? ls0_q[i] : -1;
            d = (done_q.size() > i) ? done_q[i] : -1;
            expd = exp_done_cyc(s, 0, fail, fl);
            check($sformatf("b2b_done%0d", i), d, expd);
            if (i < 2) begin
                v = (ls0_q.size() > i + 1) ? ls0_q[i + 1] : -1;
                check($sformatf("b2b_restart%0d", i), v, d + 1);
            end
        end
        check("b2b_done_busy", done_busy_bad, 0);
        check("b2b_ls_onehot", ls_bad, 0);
        begin
            logic [CIW-1:0] ei;
            logic [LW-1:0] em;
            logic [LW:0] eg;
            ref_model(ei, em, eg);
            check("b2b_pred", predicted_class, ei);
            check("b2b_max", max_logit, em);
            check("b2b_margin", margin, eg);
        end
        tick();
        check("b2b_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/inference_sequencer.md
# inference_sequencer

Parametrised controller for the MNIST inference pipeline. It replaces the fixed two-layer, auto-starting top-level sequencing with four capabilities:
- an explicit start/busy/done handshake;
- NUM_LAYERS chained layer engines, each driven by a start/done pair;
- a per-layer watchdog timeout;
- a streaming argmax over the logits buffer that also reports the top-1 to top-2 margin.

It sits between the host/board control logic and the fc layer instances. The logits memory stays outside the block.

## Interface
- NUM_LAYERS, 2: number of chained layer engines (≥1)
- NUM_CLASSES, 10: number of logits scanned by argmax (≥2)
- LOGIT_W, 32: signed logit width
- TO_W, 24: width of the timeout value
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request one inference; accepted only when busy=0
- timeout_cycles  in  TO_W  per-layer watchdog limit, sampled on accepted start; 0 = watchdog disabled
- busy  out  1  inference in progress
- done  out  1  one-cycle completion pulse
- error  out  1  last run ended by timeout; held until next accepted start
- err_layer  out  max(1,$clog2(NUM_LAYERS))  index of the layer that timed out; held with error
- layer_start  out  NUM_LAYERS  one-hot one-cycle start pulse to layer k
- layer_done  in  NUM_LAYERS  done pulse from layer k
- logit_rd  out  1  logits memory read strobe
- logit_addr  out  max(1,$clog2(NUM_CLASSES))  logits read address
- logit_data  in  LOGIT_W  signed read data, valid exactly 1 cycle after logit_rd
- predicted_class  out  max(1,$clog2(NUM_CLASSES))  argmax index
- max_logit  out  LOGIT_W  signed top-1 value
- margin  out  LOGIT_W+1  unsigned top-1 minus top-2

## Operation
- Reset values of all outputs are 0: busy, done, error, err_layer, layer_start, logit_rd, logit_addr, predicted_class, max_logit, margin. State returns to IDLE. Reset asserted mid-run aborts the run immediately, with no done pulse.
- States:
  - IDLE → L_START on start.
  - L_START → L_WAIT.
  - L_WAIT → L_START (next layer) / SCAN / FAIL.
  - SCAN → FIN.
  - FIN → IDLE.
  - FAIL → IDLE.
- L_START: drive layer_start[li]=1 for one cycle, clear the watchdog counter.
- L_WAIT: only layer_done[li] is honoured. Other bits, and any layer_done outside L_WAIT, are ignored.
  - On layer_done[li]: if li<NUM_LAYERS-1, li++ → L_START; otherwise → SCAN.
  - The watchdog counts L_WAIT cycles. If timeout_cycles≠0 and the count reaches timeout_cycles with no done → FAIL.
- SCAN: issue logit_rd on NUM_CLASSES consecutive cycles, at addresses 0..NUM_CLASSES-1. Consume logit_data one cycle later.
  - Best and second-best are tracked as signed values.
  - Index 0 initialises best; second-best initialises to the most-negative value.
  - A new value replaces best only if strictly greater, so ties resolve to the lowest index. A value equal to best updates second-best.
- FIN: register predicted_class, max_logit, and margin = best − second, computed in LOGIT_W+1 bits. Pulse done.
- FAIL: set error=1 and err_layer=li, pulse done. predicted_class, max_logit and margin keep their previous values.
- Result outputs hold until the next FIN or reset. Accepted start clears error and err_layer.
- start while busy=1 is ignored, with no queuing.

## Timing
- Start is sampled high with busy=0 at cycle 0.
  - busy=1 from cycle 1.
  - layer_start[0]=1 in cycle 1.
- layer_done[li] sampled at cycle t:
  - If not the last layer: layer_start[li+1] is driven in cycle t+1.
  - If the last layer: logit_rd with addr 0 in cycle t+1, addr NUM_CLASSES-1 in cycle t+NUM_CLASSES, last data in cycle t+NUM_CLASSES+1.
  - Outputs update and done=1 in cycle t+NUM_CLASSES+2.
- layer_done in the same cycle as the layer's own start pulse is ignored.
- Watchdog: layer_start[k] is driven in cycle s with limit T. Done is accepted in cycles s+1..s+T. If none arrives, done=1 and error=1 in cycle s+T+1.
- In the done cycle busy=0, and start is accepted in that same cycle. Back-to-back runs therefore have zero idle gap.
- At most one bit of layer_start is high, and never for more than one cycle.

## Test plan
- NUM_LAYERS=2, NUM_CLASSES=10, timeout_cycles=0, logits {-5,3,7,2,7,-1,0,6,1,-9}, layer_done 20 and 15 cycles after their starts → predicted_class=2, max_logit=7, margin=0, error=0. Check done timing against the cycle formulas.
- Logits {-100,…,-100, 50 at index 9} → predicted_class=9, margin=150. Logits {0x7FFFFFFF, 0x80000000, rest 0x80000000} → margin=0xFFFFFFFF; the 33-bit result must not wrap.
- timeout_cycles=8, layer 1 never completes → done+error in cycle s+9 with err_layer=1. Results are unchanged from the previous run. The next start clears error.
- Wrong-layer layer_done[1] pulsed while waiting on layer 0, and a start pulse while busy → both ignored, with no extra layer_start pulses and no second run.
- Reset asserted during SCAN → all outputs are 0 the next cycle, with no done pulse. A fresh start then completes normally.
- start held high continuously → back-to-back runs. Each done cycle coincides with the next acceptance, and layer_start[0] follows in the next cycle.
